// File: rtl/ninjakun_shram.sv
// Shared-RAM arbiter for the dual-CPU board: two CPU buses share one
// single-port synchronous RAM. Each access takes three states
// (grant/ACC/CAP). The CPU that was not served last wins a tie, and the
// per-CPU WAIT stays high until that CPU's access has completed.

// Per-CPU front end. It holds the done flag (one access per strobe),
// derives the request and WAIT, and keeps the registered read data.
module ninjakun_shram_port #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          rd,
    input  logic          wr,
    input  logic          fin_ok,   // access accepted for this CPU this cycle
    input  logic          fin_rd,   // accepted access was a read
    input  logic [DW-1:0] ram_di,
    output logic          act,
    output logic          req,
    output logic [DW-1:0] di
);
    logic done;

    assign act = cs & (rd | wr);
    assign req = act & ~done;

    // done latches on completion and is released once the CPU lets go of the strobe/select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            di   <= '0;
        end else begin
            if (!act)
                done <= 1'b0;
            else if (fin_ok)
                done <= 1'b1;
            if (fin_ok && fin_rd)
                di <= ram_di;
        end
    end
endmodule

// Top level: the arbitration FSM and the RAM-side registers.
module ninjakun_shram_arb #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          MCLK,
    input  logic          RESET,
    input  logic          CS_SH0,
    input  logic          CS_SH1,
    input  logic [AW-1:0] CP0AD,
    input  logic [AW-1:0] CP1AD,
    input  logic          CP0RD,
    input  logic          CP1RD,
    input  logic          CP0WR,
    input  logic          CP1WR,
    input  logic [DW-1:0] CP0DO,
    input  logic [DW-1:0] CP1DO,
    output logic [DW-1:0] CP0DI,
    output logic [DW-1:0] CP1DI,
    output logic          CP0WAIT,
    output logic          CP1WAIT,
    output logic [AW-1:0] RAM_AD,
    output logic [DW-1:0] RAM_DO,
    output logic          RAM_WE,
    input  logic [DW-1:0] RAM_DI
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        CAP0 = 3'd3,
        CAP1 = 3'd4
    } state_t;

    state_t state;

    logic [1:0]          cs, rd, wr, act, req, cap_ok;
    logic [1:0][AW-1:0]  ad;
    logic [1:0][DW-1:0]  wdat, rdat;

    logic          last_gnt;   // CPU served most recently; loses the next tie
    logic          live;       // owner kept CS and strobe up for the whole access
    logic          acc_wr;     // latched access type at grant
    logic          pick;       // CPU to grant from IDLE
    logic          own;        // CPU currently owning the RAM
    logic [AW-1:0] ram_ad_q;
    logic [DW-1:0] ram_do_q;
    logic          ram_we_q;

    assign cs   = {CS_SH1, CS_SH0};
    assign rd   = {CP1RD, CP0RD};
    assign wr   = {CP1WR, CP0WR};
    assign ad   = {CP1AD, CP0AD};
    assign wdat = {CP1DO, CP0DO};

    for (genvar i = 0; i < 2; i++) begin : g_port
        ninjakun_shram_port #(.DW(DW)) u_port (
            .clk    (MCLK),
            .rst    (RESET),
            .cs     (cs[i]),
            .rd     (rd[i]),
            .wr     (wr[i]),
            .fin_ok (cap_ok[i]),
            .fin_rd (~acc_wr),
            .ram_di (RAM_DI),
            .act    (act[i]),
            .req    (req[i]),
            .di     (rdat[i])
        );
    end

    // Tie goes to the CPU not served last; otherwise the lone requester.
    // Also decode which CPU owns the RAM from the current state.
    always_comb begin
        pick = (&req) ? ~last_gnt : req[1];
        own  = (state == ACC1) || (state == CAP1);
    end

    // A completion counts only if the owner still holds CS and the strobe
    assign cap_ok[0] = (state == CAP0) & live & act[0];
    assign cap_ok[1] = (state == CAP1) & live & act[1];

    // Arbitration FSM. The RAM address, data and write enable are registered
    // at grant, so WE is high only during ACC.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            live     <= 1'b0;
            acc_wr   <= 1'b0;
            ram_ad_q <= '0;
            ram_do_q <= '0;
            ram_we_q <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        ram_ad_q <= ad[pick];
                        ram_do_q <= wdat[pick];
                        ram_we_q <= wr[pick];    // RD+WR together is a write
                        acc_wr   <= wr[pick];
                        live     <= 1'b1;
                        state    <= pick ? ACC1 : ACC0;
                    end
                end
                ACC0: begin
                    live  <= live & act[0];
                    state <= CAP0;
                end
                ACC1: begin
                    live  <= live & act[1];
                    state <= CAP1;
                end
                CAP0, CAP1: begin
                    last_gnt <= own;
                    live     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign RAM_AD  = ram_ad_q;
    assign RAM_DO  = ram_do_q;
    assign RAM_WE  = ram_we_q;
    assign CP0DI   = rdat[0];
    assign CP1DI   = rdat[1];
    assign CP0WAIT = req[0];
    assign CP1WAIT = req[1];
endmodule

// File: tb/tb_ninjakun_shram_arb.sv
// Bench for ninjakun_shram_arb. It covers a directed table of accesses, a
// few multi-cycle corner cases (held strobe, reset mid-access, select
// dropped), and randomized rounds checked against a transaction-level model.
module tb_ninjakun_shram_arb;
    localparam int AW = 11;
    localparam int DW = 8;

    logic          MCLK = 1'b0;
    logic          RESET;
    logic          CS_SH0, CS_SH1, CP0RD, CP0WR, CP1RD, CP1WR;
    logic [AW-1:0] CP0AD, CP1AD, RAM_AD;
    logic [DW-1:0] CP0DO, CP1DO, CP0DI, CP1DI, RAM_DO;
    logic [DW-1:0] RAM_DI = '0;
    logic          CP0WAIT, CP1WAIT, RAM_WE;

    always #5 MCLK = ~MCLK;

    ninjakun_shram_arb #(.AW(AW), .DW(DW)) dut (
        .MCLK(MCLK), .RESET(RESET),
        .CS_SH0(CS_SH0), .CS_SH1(CS_SH1),
        .CP0AD(CP0AD), .CP1AD(CP1AD),
        .CP0RD(CP0RD), .CP1RD(CP1RD),
        .CP0WR(CP0WR), .CP1WR(CP1WR),
        .CP0DO(CP0DO), .CP1DO(CP1DO),
        .CP0DI(CP0DI), .CP1DI(CP1DI),
        .CP0WAIT(CP0WAIT), .CP1WAIT(CP1WAIT),
        .RAM_AD(RAM_AD), .RAM_DO(RAM_DO), .RAM_WE(RAM_WE),
        .RAM_DI(RAM_DI)
    );

    // Synchronous single-port RAM (read-first) plus a write-pulse monitor
    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
    int            we_cnt = 0;
    int            we_dbl = 0;
    logic          we_prev = 1'b0;
    logic [AW-1:0] last_wad = '0;
    logic [DW-1:0] last_wdat = '0;

    always @(posedge MCLK) begin
        if (RAM_WE) begin
            mem[RAM_AD] <= RAM_DO;
            we_cnt      <= we_cnt + 1;
            last_wad    <= RAM_AD;
            last_wdat   <= RAM_DO;
        end
        if (RAM_WE && we_prev) we_dbl <= we_dbl + 1;
        we_prev <= RAM_WE;
        RAM_DI  <= mem[RAM_AD];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_bus();
        CS_SH0 = 1'b0; CP0RD = 1'b0; CP0WR = 1'b0;
        CS_SH1 = 1'b0; CP1RD = 1'b0; CP1WR = 1'b0;
    endtask

    task automatic drive(input bit a0, input bit r0, input bit w0, input logic [AW-1:0] ad0, input logic [DW-1:0] d0,
                         input bit a1, input bit r1, input bit w1, input logic [AW-1:0] ad1, input logic [DW-1:0] d1);
        CS_SH0 = a0; CP0RD = r0; CP0WR = w0; CP0AD = ad0; CP0DO = d0;
        CS_SH1 = a1; CP1RD = r1; CP1WR = w1; CP1AD = ad1; CP1DO = d1;
    endtask

    // Count the cycles each WAIT stays high after the first edge that sees the request
    task automatic count_waits(input int ncyc, output int w0, output int w1);
        w0 = 0; w1 = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge MCLK); @(negedge MCLK);
            if (CP0WAIT) w0++;
            if (CP1WAIT) w1++;
        end
    endtask

    // One bus round: present the access at a negedge, hold for 8 cycles, then release
    task automatic run_round(input bit a0, input bit r0, input bit w0, input logic [AW-1:0] ad0, input logic [DW-1:0] d0,
                             input bit a1, input bit r1, input bit w1, input logic [AW-1:0] ad1, input logic [DW-1:0] d1,
                             output int wc0, output int wc1, output int wed);
        int we0;
        we0 = we_cnt;
        drive(a0, r0, w0, ad0, d0, a1, r1, w1, ad1, d1);
        count_waits(8, wc0, wc1);
        idle_bus();
        @(posedge MCLK); @(negedge MCLK);
        @(posedge MCLK); @(negedge MCLK);
        wed = we_cnt - we0;
    endtask

    typedef struct {
        bit a0, a1, r0, w0, r1, w1;
        logic [AW-1:0] ad0, ad1;
        logic [DW-1:0] d0, d1;
        int ew0, ew1, ewe;
        logic [DW-1:0] edi0, edi1;
        logic [AW-1:0] ewad;
        logic [DW-1:0] ewdat;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int wc0, wc1, wed, we0;
        logic [DW-1:0] rmem [8];
        logic [DW-1:0] mdi  [2];
        bit   ract [2];
        bit   rwr  [2];
        bit   rrd  [2];
        int   ridx [2];
        logic [DW-1:0] rdat [2];
        int   ew   [2];
        bit   last;
        int   first, nwr, pos;

        // a0,a1, r0,w0, r1,w1, ad0,ad1, d0,d1, ew0,ew1,ewe, edi0,edi1, ewad,ewdat
        tbl[0] = '{1'b1,1'b0, 1'b0,1'b1, 1'b0,1'b0, 11'h123,11'h000, 8'h5A,8'h00, 2,0,1, 8'h00,8'h00, 11'h123,8'h5A};
        tbl[1] = '{1'b0,1'b1, 1'b0,1'b0, 1'b1,1'b0, 11'h000,11'h123, 8'h00,8'h00, 0,2,0, 8'h00,8'h5A, 11'h000,8'h00};
        tbl[2] = '{1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b0, 11'h123,11'h123, 8'h00,8'h00, 2,5,0, 8'h5A,8'h5A, 11'h000,8'h00};
        tbl[3] = '{1'b1,1'b0, 1'b0,1'b1, 1'b0,1'b0, 11'h200,11'h000, 8'h33,8'h00, 2,0,1, 8'h5A,8'h5A, 11'h200,8'h33};
        tbl[4] = '{1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b0, 11'h200,11'h123, 8'h00,8'h00, 5,2,0, 8'h33,8'h5A, 11'h000,8'h00};
        tbl[5] = '{1'b1,1'b1, 1'b0,1'b1, 1'b0,1'b1, 11'h010,11'h010, 8'h22,8'h11, 5,2,2, 8'h33,8'h5A, 11'h010,8'h22};
        tbl[6] = '{1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b0, 11'h010,11'h010, 8'h00,8'h00, 5,2,0, 8'h22,8'h22, 11'h000,8'h00};
        tbl[7] = '{1'b1,1'b0, 1'b1,1'b1, 1'b0,1'b0, 11'h010,11'h000, 8'h44,8'h00, 2,0,1, 8'h22,8'h22, 11'h010,8'h44};
        tbl[8] = '{1'b0,1'b1, 1'b0,1'b0, 1'b1,1'b0, 11'h000,11'h010, 8'h00,8'h00, 0,2,0, 8'h22,8'h44, 11'h000,8'h00};

        idle_bus();
        CP0AD = '0; CP1AD = '0; CP0DO = '0; CP1DO = '0;
        RESET = 1'b1;
        repeat (3) @(posedge MCLK);
        @(negedge MCLK);
        chk("reset.RAM_WE", RAM_WE, 0);
        chk("reset.RAM_AD", RAM_AD, 0);
        chk("reset.RAM_DO", RAM_DO, 0);
        chk("reset.CP0DI",  CP0DI, 0);
        chk("reset.CP1DI",  CP1DI, 0);
        chk("reset.WAIT",   {CP1WAIT, CP0WAIT}, 0);
        RESET = 1'b0;
        @(negedge MCLK);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_round(tbl[i].a0, tbl[i].r0, tbl[i].w0, tbl[i].ad0, tbl[i].d0,
                      tbl[i].a1, tbl[i].r1, tbl[i].w1, tbl[i].ad1, tbl[i].d1, wc0, wc1, wed);
            chk($sformatf("tbl%0d.wait0", i), wc0, tbl[i].ew0);
            chk($sformatf("tbl%0d.wait1", i), wc1, tbl[i].ew1);
            chk($sformatf("tbl%0d.we_pulses", i), wed, tbl[i].ewe);
            chk($sformatf("tbl%0d.CP0DI", i), CP0DI, tbl[i].edi0);
            chk($sformatf("tbl%0d.CP1DI", i), CP1DI, tbl[i].edi1);
            if (tbl[i].ewe > 0) begin
                chk($sformatf("tbl%0d.wr_addr", i), last_wad, tbl[i].ewad);
                chk($sformatf("tbl%0d.wr_data", i), last_wdat, tbl[i].ewdat);
            end
        end

        // Held strobe: one write for a 10-cycle WR, a second only after WR drops
        we0 = we_cnt;
        drive(1'b1, 1'b0, 1'b1, 11'h300, 8'h77, 1'b0, 1'b0, 1'b0, 11'h000, 8'h00);
        count_waits(10, wc0, wc1);
        chk("hold.wait0", wc0, 2);
        chk("hold.we_pulses", we_cnt - we0, 1);
        CP0WR = 1'b0;
        @(posedge MCLK); @(negedge MCLK);
        CP0WR = 1'b1; CP0DO = 8'h78;
        count_waits(5, wc0, wc1);
        chk("rehold.wait0", wc0, 2);
        chk("rehold.we_pulses", we_cnt - we0, 2);
        chk("rehold.mem", mem[11'h300], 8'h78);
        idle_bus();
        @(posedge MCLK); @(negedge MCLK);

        // Reset while CPU0's write is in ACC0
        we0 = we_cnt;
        drive(1'b1, 1'b0, 1'b1, 11'h301, 8'h99, 1'b0, 1'b0, 1'b0, 11'h000, 8'h00);
        @(posedge MCLK); #1;
        chk("rstacc.we_before", RAM_WE, 1);
        RESET = 1'b1; #1;
        chk("rstacc.RAM_WE", RAM_WE, 0);
        chk("rstacc.RAM_AD", RAM_AD, 0);
        chk("rstacc.RAM_DO", RAM_DO, 0);
        chk("rstacc.CP0DI", CP0DI, 0);
        chk("rstacc.CP1DI", CP1DI, 0);
        @(negedge MCLK);
        chk("rstacc.aborted", we_cnt - we0, 0);
        RESET = 1'b0;
        count_waits(6, wc0, wc1);
        chk("rstacc.wait0", wc0, 2);
        chk("rstacc.we_pulses", we_cnt - we0, 1);
        chk("rstacc.mem", mem[11'h301], 8'h99);
        idle_bus();
        @(posedge MCLK); @(negedge MCLK);

        // CS_SH0 dropped during ACC0 of a read; CPU1 then served
        drive(1'b1, 1'b1, 1'b0, 11'h300, 8'h00, 1'b0, 1'b0, 1'b0, 11'h000, 8'h00);
        @(posedge MCLK); @(negedge MCLK);
        CS_SH0 = 1'b0;
        CS_SH1 = 1'b1; CP1RD = 1'b1; CP1AD = 11'h301;
        count_waits(7, wc0, wc1);
        chk("drop.wait0", wc0, 0);
        chk("drop.wait1", wc1, 4);
        chk("drop.CP0DI", CP0DI, 8'h00);
        chk("drop.CP1DI", CP1DI, 8'h99);
        CS_SH1 = 1'b0; CP1RD = 1'b0;
        CS_SH0 = 1'b1; #1;
        chk("drop.rereq", CP0WAIT, 1);
        count_waits(5, wc0, wc1);
        chk("drop.rewait0", wc0, 2);
        chk("drop.reCP0DI", CP0DI, 8'h78);
        idle_bus();
        @(posedge MCLK); @(negedge MCLK);

        // Randomized rounds against a transaction-level model (fresh reset first)
        RESET = 1'b1;
        @(posedge MCLK); @(negedge MCLK);
        RESET = 1'b0;
        @(negedge MCLK);
        for (int j = 0; j < 8; j++) rmem[j] = '0;
        mdi[0] = '0; mdi[1] = '0;
        last = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int amask, op;
            amask = $urandom_range(1, 3);
            for (int c = 0; c < 2; c++) begin
                ract[c] = ((amask >> c) & 1) != 0;
                op      = $urandom_range(0, 2);   // 0 read, 1 write, 2 RD+WR
                rrd[c]  = (op != 1);
                rwr[c]  = (op != 0);
                ridx[c] = $urandom_range(0, 7);
                rdat[c] = DW'($urandom);
                ew[c]   = 0;
            end
            // Serve order: tie goes to the CPU not served last
            if (ract[0] && ract[1]) first = last ? 0 : 1;
            else                    first = ract[0] ? 0 : 1;
            nwr = 0;
            pos = 0;
            for (int s = 0; s < 2; s++) begin
                int c;
                c = (s == 0) ? first : 1 - first;
                if (ract[c]) begin
                    ew[c] = (pos == 0) ? 2 : 5;
                    pos++;
                    if (rwr[c]) begin
                        rmem[ridx[c]] = rdat[c];
                        nwr++;
                    end else begin
                        mdi[c] = rmem[ridx[c]];
                    end
                    last = (c != 0);
                end
            end
            run_round(ract[0], rrd[0] & ract[0], rwr[0] & ract[0], 11'h7F0 + 11'(ridx[0]), rdat[0],
                      ract[1], rrd[1] & ract[1], rwr[1] & ract[1], 11'h7F0 + 11'(ridx[1]), rdat[1],
                      wc0, wc1, wed);
            chk($sformatf("rnd%0d.wait0", r), wc0, ew[0]);
            chk($sformatf("rnd%0d.wait1", r), wc1, ew[1]);
            chk($sformatf("rnd%0d.we_pulses", r), wed, nwr);
            chk($sformatf("rnd%0d.CP0DI", r), CP0DI, mdi[0]);
            chk($sformatf("rnd%0d.CP1DI", r), CP1DI, mdi[1]);
        end

        chk("we_back_to_back", we_dbl, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
